// File: rtl/mdma_pkg.sv
// Shared types and default sizing for the uDMA request scheduler.
package mdma_pkg;

  localparam int MDMA_CHNLC = 8;
  localparam int MDMA_QW    = 4;
  localparam int MDMA_TOW   = 16;

  // Scheduler states: arbitrate, hold request, wait for transfer end.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACT  = 2'd2
  } mdma_sched_st_e;

  // Per-channel configuration bundle.
  typedef struct packed {
    logic en;
    logic prio;
    logic single;
  } mdma_ch_cfg_t;

endpackage : mdma_pkg

// File: rtl/mdma_rrarb.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping at N.
module mdma_rrarb #(
  parameter int N = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // First requester at or after ptr wins; the search wraps once around.
  always_comb begin
    logic [IW-1:0] cand;
    logic          found;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found         = 1'b1;
        gnt_idx       = cand;
        gnt_oh[cand]  = 1'b1;
      end else begin
        found = found;
      end
    end
    any = found;
  end

endmodule : mdma_rrarb

// File: rtl/mdma_reqsched.sv
// Request scheduler in front of the PL230 uDMA request interface.
// Queues per-channel events, arbitrates two priority levels with round-robin
// inside each level, keeps one request outstanding and reports overflow and
// request timeouts as sticky error bits.
module mdma_reqsched
  import mdma_pkg::*;
#(
  parameter int CHNLC = MDMA_CHNLC,
  parameter int QW    = MDMA_QW,
  parameter int TOW   = MDMA_TOW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHNLC-1:0]      ev_pulse,
  input  logic [CHNLC-1:0]      cfg_en,
  input  logic [CHNLC-1:0]      cfg_prio,
  input  logic [CHNLC-1:0]      cfg_single,
  input  logic [TOW-1:0]        cfg_timeout,
  input  logic                  err_clr,
  input  logic [CHNLC-1:0]      dma_active,
  input  logic [CHNLC-1:0]      dma_done,
  output logic [CHNLC-1:0]      dma_req,
  output logic [CHNLC-1:0]      dma_sreq,
  output logic [CHNLC*QW-1:0]   q_len,
  output logic [CHNLC-1:0]      q_ovf,
  output logic [CHNLC-1:0]      err_to,
  output logic                  busy
);

  localparam int IW = (CHNLC > 1) ? $clog2(CHNLC) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(CHNLC - 1);
  localparam logic [QW-1:0]  Q_MAX    = {QW{1'b1}};
  localparam logic [TOW-1:0] TO_MAX   = {TOW{1'b1}};

  // Next round-robin start position after a grant to idx.
  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    logic [IW-1:0] nxt;
    if (idx == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = idx + IW'(1'b1);
    end
    return nxt;
  endfunction

  mdma_ch_cfg_t     cfg_s [CHNLC];
  logic [CHNLC-1:0] en_s, prio_s, single_s, elig_s;
  logic [CHNLC-1:0] deq_s, to_set_s;

  mdma_sched_st_e   state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [CHNLC-1:0] gnt_oh_q, gnt_oh_d;
  logic             lvl_q, lvl_d;
  logic [IW-1:0]    rr_hi_q, rr_hi_d, rr_lo_q, rr_lo_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic [CHNLC-1:0] act_prev_q;
  logic [CHNLC-1:0] dma_req_q, dma_req_d, dma_sreq_q, dma_sreq_d;
  logic [CHNLC-1:0] err_to_q, err_to_d;
  logic             busy_q;

  logic [CHNLC-1:0] hi_oh_s, lo_oh_s, arb_oh_s;
  logic [IW-1:0]    hi_idx_s, lo_idx_s, arb_idx_s;
  logic             hi_any_s, lo_any_s, arb_any_s;

  // Per-channel configuration bundle and queue counters.
  for (genvar i = 0; i < CHNLC; i++) begin : g_ch
    logic [QW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          inc_s;

    assign cfg_s[i]    = '{en: cfg_en[i], prio: cfg_prio[i], single: cfg_single[i]};
    assign en_s[i]     = cfg_s[i].en;
    assign prio_s[i]   = cfg_s[i].prio;
    assign single_s[i] = cfg_s[i].single;
    assign inc_s       = ev_pulse[i] & en_s[i];
    assign elig_s[i]   = en_s[i] & (cnt_q != '0);

    // Queue count: disable clears, inc and dec cancel, saturate at max.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (!en_s[i]) begin
        cnt_d = '0;
      end else if (inc_s && !deq_s[i]) begin
        if (cnt_q == Q_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + QW'(1'b1);
        end
      end else if (!inc_s && deq_s[i]) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - QW'(1'b1);
        end else begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q;
      end
      // Sticky overflow: a set in the same cycle as a clear wins.
      if (inc_s && !deq_s[i] && (cnt_q == Q_MAX)) begin
        ovf_d = 1'b1;
      end else if (err_clr) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end

    // Queue count and overflow registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign q_len[i*QW +: QW] = cnt_q;
    assign q_ovf[i]          = ovf_q;
  end

  mdma_rrarb #(.N(CHNLC)) u_arb_hi (
    .req     (elig_s & prio_s),
    .ptr     (rr_hi_q),
    .gnt_oh  (hi_oh_s),
    .gnt_idx (hi_idx_s),
    .any     (hi_any_s)
  );

  mdma_rrarb #(.N(CHNLC)) u_arb_lo (
    .req     (elig_s & ~prio_s),
    .ptr     (rr_lo_q),
    .gnt_oh  (lo_oh_s),
    .gnt_idx (lo_idx_s),
    .any     (lo_any_s)
  );

  assign arb_any_s = hi_any_s | lo_any_s;
  assign arb_idx_s = hi_any_s ? hi_idx_s : lo_idx_s;
  assign arb_oh_s  = hi_any_s ? hi_oh_s : lo_oh_s;

  // Scheduler next state: grant capture, request hold, completion tracking.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    lvl_d    = lvl_q;
    rr_hi_d  = rr_hi_q;
    rr_lo_d  = rr_lo_q;
    to_cnt_d = to_cnt_q;
    deq_s    = '0;
    to_set_s = '0;
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          state_d  = REQ;
          gnt_d    = arb_idx_s;
          gnt_oh_d = arb_oh_s;
          lvl_d    = hi_any_s;
          to_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (!en_s[gnt_q]) begin
          // Queue is cleared by the disable path; nothing to dequeue here.
          state_d = IDLE;
        end else if (dma_active[gnt_q]) begin
          state_d = ACT;
        end else if ((cfg_timeout != '0) && (to_cnt_q >= cfg_timeout)) begin
          to_set_s[gnt_q] = 1'b1;
          deq_s[gnt_q]    = 1'b1;
          state_d         = IDLE;
        end else begin
          to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : (to_cnt_q + TOW'(1'b1));
        end
      end
      ACT: begin
        // Either dma_done or active dropping ends the transfer, whichever comes first.
        if (dma_done[gnt_q] || (act_prev_q[gnt_q] && !dma_active[gnt_q])) begin
          deq_s[gnt_q] = 1'b1;
          state_d      = IDLE;
          if (lvl_q) begin
            rr_hi_d = rr_next(gnt_q);
          end else begin
            rr_lo_d = rr_next(gnt_q);
          end
        end else begin
          state_d = ACT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request lines follow the next state so they change only at clock edges.
  always_comb begin
    dma_req_d  = '0;
    dma_sreq_d = '0;
    if (state_d == REQ) begin
      dma_req_d  = gnt_oh_d & ~single_s;
      dma_sreq_d = gnt_oh_d & single_s;
    end else begin
      dma_req_d  = '0;
      dma_sreq_d = '0;
    end
    err_to_d = to_set_s | (err_clr ? {CHNLC{1'b0}} : err_to_q);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      lvl_q      <= 1'b0;
      rr_hi_q    <= '0;
      rr_lo_q    <= '0;
      to_cnt_q   <= '0;
      act_prev_q <= '0;
      dma_req_q  <= '0;
      dma_sreq_q <= '0;
      err_to_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_oh_q   <= gnt_oh_d;
      lvl_q      <= lvl_d;
      rr_hi_q    <= rr_hi_d;
      rr_lo_q    <= rr_lo_d;
      to_cnt_q   <= to_cnt_d;
      act_prev_q <= dma_active;
      dma_req_q  <= dma_req_d;
      dma_sreq_q <= dma_sreq_d;
      err_to_q   <= err_to_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign dma_req  = dma_req_q;
  assign dma_sreq = dma_sreq_q;
  assign err_to   = err_to_q;
  assign busy     = busy_q;

endmodule : mdma_reqsched

// File: tb/tb_mdma_reqsched.sv
// Directed bench for mdma_reqsched with a hand-driven uDMA handshake.
module tb_mdma_reqsched;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ev_pulse, cfg_en, cfg_prio, cfg_single;
  logic [15:0] cfg_timeout;
  logic        err_clr;
  logic [7:0]  dma_active, dma_done;
  logic [7:0]  dma_req, dma_sreq, q_ovf, err_to;
  logic [31:0] q_len;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mdma_reqsched dut (
    .clk        (clk),
    .reset      (reset),
    .ev_pulse   (ev_pulse),
    .cfg_en     (cfg_en),
    .cfg_prio   (cfg_prio),
    .cfg_single (cfg_single),
    .cfg_timeout(cfg_timeout),
    .err_clr    (err_clr),
    .dma_active (dma_active),
    .dma_done   (dma_done),
    .dma_req    (dma_req),
    .dma_sreq   (dma_sreq),
    .q_len      (q_len),
    .q_ovf      (q_ovf),
    .err_to     (err_to),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] qlen(input int ch);
    return q_len[ch*4 +: 4];
  endfunction

  task automatic do_reset();
    reset = 1'b1; ev_pulse = '0; cfg_en = '0; cfg_prio = '0; cfg_single = '0;
    cfg_timeout = '0; err_clr = 1'b0; dma_active = '0; dma_done = '0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m, input int n);
    ev_pulse = m;
    step(n);
    ev_pulse = '0;
  endtask

  // Wait for a request, then act as the uDMA: active, then done or active drop.
  task automatic serve(input bit via_done, output int ch, output bit is_s);
    int n = 0;
    ch = -1; is_s = 1'b0;
    while (((dma_req | dma_sreq) == 8'h00) && (n < 50)) begin
      step(1);
      n++;
    end
    chk("req_wait", 64'(n < 50), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (dma_req[i] || dma_sreq[i]) begin
        ch = i;
        is_s = dma_sreq[i];
      end
    end
    if (ch >= 0) begin
      chk("qlen_nonzero_at_grant", 64'(qlen(ch) != 4'd0), 64'd1);
      dma_active[ch] = 1'b1;
      step(1);
      chk("req_drop_on_active", 64'(dma_req | dma_sreq), 64'd0);
      if (via_done) dma_done[ch] = 1'b1;
      else          dma_active[ch] = 1'b0;
      step(1);
      dma_active = '0;
      dma_done   = '0;
    end
  endtask

  initial begin
    int ch;
    bit is_s;
    int n;
    int exp_ord[4];

    // Reset values
    do_reset();
    step(1);
    chk("rst_req", 64'(dma_req), 64'd0);
    chk("rst_sreq", 64'(dma_sreq), 64'd0);
    chk("rst_qlen", 64'(q_len), 64'd0);
    chk("rst_ovf", 64'(q_ovf), 64'd0);
    chk("rst_errto", 64'(err_to), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single channel: three events on ch2, three serviced transfers
    cfg_en = 8'h04;
    pulse(8'h04, 3);
    chk("single_qlen3", 64'(qlen(2)), 64'd3);
    chk("single_req", 64'(dma_req), 64'h04);
    chk("single_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      serve(k[0], ch, is_s);
      chk("single_ch", 64'(ch), 64'd2);
      chk("single_burst", 64'(is_s), 64'd0);
      chk("single_qlen_dec", 64'(qlen(2)), 64'(2 - k));
    end
    step(1);
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_idle_req", 64'(dma_req), 64'd0);

    // Round-robin in low level: ch1 twice, ch3, ch5 from pointer 0
    do_reset();
    cfg_en = 8'h2A;
    pulse(8'h2A, 1);
    pulse(8'h02, 1);
    exp_ord = '{1, 3, 5, 1};
    for (int k = 0; k < 4; k++) begin
      serve(k[0], ch, is_s);
      chk("rr_order", 64'(ch), 64'(exp_ord[k]));
    end
    // Refill continues after the last grant (ch1): 3, 5, 1
    pulse(8'h2A, 1);
    exp_ord = '{3, 5, 1, 0};
    for (int k = 0; k < 3; k++) begin
      serve(1'b1, ch, is_s);
      chk("rr_refill_order", 64'(ch), 64'(exp_ord[k]));
    end
    step(1);
    chk("rr_qlen_empty", 64'(q_len), 64'd0);

    // Priority: ch6 high (single), ch0 low, two events each
    do_reset();
    cfg_en = 8'h41; cfg_prio = 8'h40; cfg_single = 8'h40;
    pulse(8'h41, 2);
    exp_ord = '{6, 6, 0, 0};
    for (int k = 0; k < 4; k++) begin
      serve(1'b1, ch, is_s);
      chk("prio_order", 64'(ch), 64'(exp_ord[k]));
      chk("prio_single", 64'(is_s), 64'(k < 2));
    end

    // Saturation and overflow on ch4
    do_reset();
    cfg_en = 8'h10;
    pulse(8'h10, 15);
    chk("sat_qlen15", 64'(qlen(4)), 64'd15);
    chk("sat_no_ovf", 64'(q_ovf), 64'd0);
    pulse(8'h10, 1);
    chk("sat_qlen_hold", 64'(qlen(4)), 64'd15);
    chk("sat_ovf", 64'(q_ovf), 64'h10);
    ev_pulse = 8'h10; err_clr = 1'b1;
    step(1);
    ev_pulse = '0;
    chk("ovf_set_wins", 64'(q_ovf), 64'h10);
    step(1);
    err_clr = 1'b0;
    chk("ovf_cleared", 64'(q_ovf), 64'd0);
    serve(1'b1, ch, is_s);
    chk("sat_after_serve", 64'(qlen(4)), 64'd14);
    step(1);
    chk("sat_regrant", 64'(dma_req), 64'h10);
    // Disable while requesting
    cfg_en = 8'h00;
    step(1);
    chk("dis_req_drop", 64'(dma_req), 64'd0);
    chk("dis_qlen0", 64'(qlen(4)), 64'd0);
    chk("dis_busy", 64'(busy), 64'd0);

    // Timeout on ch3 with no dma_active
    do_reset();
    cfg_en = 8'h08; cfg_timeout = 16'd10;
    pulse(8'h08, 1);
    step(1);
    chk("to_req", 64'(dma_req), 64'h08);
    n = 0;
    while ((err_to == 8'h00) && (n < 40)) begin
      step(1);
      n++;
    end
    chk("to_latency", 64'(n), 64'd11);
    chk("to_errbit", 64'(err_to), 64'h08);
    chk("to_qlen", 64'(qlen(3)), 64'd0);
    chk("to_req_drop", 64'(dma_req), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("to_clr", 64'(err_to), 64'd0);

    // Reset during an active transfer on ch0
    do_reset();
    cfg_en = 8'h01;
    pulse(8'h01, 1);
    step(1);
    chk("ract_req", 64'(dma_req), 64'h01);
    dma_active[0] = 1'b1;
    step(1);
    chk("ract_busy", 64'(busy), 64'd1);
    dma_done[1] = 1'b1;
    step(1);
    dma_done = '0;
    chk("ract_foreign_done", 64'(busy), 64'd1);
    chk("ract_qlen", 64'(qlen(0)), 64'd1);
    reset = 1'b1;
    step(1);
    chk("ract_rst_req", 64'(dma_req | dma_sreq), 64'd0);
    chk("ract_rst_qlen", 64'(q_len), 64'd0);
    chk("ract_rst_busy", 64'(busy), 64'd0);
    chk("ract_rst_err", 64'(q_ovf | err_to), 64'd0);
    reset = 1'b0;
    dma_active = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mdma_reqsched
